// File: rtl/uart_rx.sv
// UART receiver: 1 start, DWIDTH data bits LSB first, 2 stop bits; rxvalid rises 1 cycle after the STOP2 mid-bit sample.
// The held byte waits for core_rxready; a byte completing while the held one is unconsumed is dropped with an o_overrun pulse.
module uart_rx #(
  parameter DWIDTH = 4'd8,
  parameter int CLK_RATE = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic              uart_clk,
  input  logic              uart_rst,
  input  logic              i_uart_rx,
  output logic [DWIDTH-1:0] core_rxdata,
  output logic              core_rxvalid,
  input  logic              core_rxready,
  output logic              o_uart_rx_busy,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int DW   = DWIDTH;
  localparam int CPB  = CLK_RATE / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW   = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic          sync1, rx_s;
  logic          done, ferr;

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rx_s  <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    done      = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Mid start bit: a line back high by now was a glitch.
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == IDX_LAST) state_nxt = STOP1;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP1: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = STOP2;
          end else begin
            ferr      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      STOP2: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s) done = 1'b1;
          else      ferr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      core_rxdata  <= '0;
      core_rxvalid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shreg       <= shreg_nxt;
      o_frame_err <= ferr;
      o_overrun   <= 1'b0;
      if (done) begin
        // A byte landing in the same cycle the core consumes the old one replaces it seamlessly.
        if (!core_rxvalid || core_rxready) begin
          core_rxdata  <= shreg;
          core_rxvalid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (core_rxvalid && core_rxready) begin
        core_rxvalid <= 1'b0;
      end
    end
  end

  assign o_uart_rx_busy = (state != IDLE);

endmodule
